// File: rtl/readout_defs_pkg.sv
// Shared definitions for the result readout sequencer and its key synchronizer.
package readout_defs_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam logic        KEY_RST_VAL = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;

endpackage

// File: rtl/result_readout_seq_key_press_sync.sv
// Synchronizes an asynchronous active-low key and emits a one-cycle pulse per falling edge.
module key_press_sync
  import readout_defs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  assign hist_d = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{KEY_RST_VAL}};
      hist_q <= KEY_RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // High for one cycle when the synchronized key goes from released to pressed.
  assign press = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/result_readout_seq.sv
// Latches compute results on done, acknowledges, and pages them onto LEDs by key press.
// Optional checksum slot enabled by defining READOUT_CHECKSUM_EN.
module result_readout_seq
  import readout_defs_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_RESULTS = 2,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          done,
  input  logic [NUM_RESULTS*DATA_W-1:0] res_bus,
  input  logic                          key_n,
  input  logic                          clear,
  output logic                          ack,
  output logic                          valid,
  output logic [DATA_W-1:0]             led_data,
  output logic [IDX_W-1:0]              led_idx
);

`ifdef READOUT_CHECKSUM_EN
  localparam int unsigned LAST_SLOT = NUM_RESULTS;
`else
  localparam int unsigned LAST_SLOT = NUM_RESULTS - 1;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] res_q [NUM_RESULTS];
  logic [DATA_W-1:0] res_d [NUM_RESULTS];
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_next;
  logic [DATA_W-1:0] page_word;
  logic              press;

  key_press_sync u_key_sync (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .press (press)
  );

`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
  logic [DATA_W-1:0] bus_xor;

  always_comb begin
    bus_xor = '0;
    for (int unsigned k = 0; k < NUM_RESULTS; k++) begin
      bus_xor = bus_xor ^ res_bus[k*DATA_W +: DATA_W];
    end
  end
`endif

  // Wrap by comparing against the last slot rather than relying on IDX_W overflow.
  assign idx_next = (idx_q == IDX_W'(LAST_SLOT)) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    page_word = '0;
    for (int unsigned k = 0; k < NUM_RESULTS; k++) begin
      if (idx_next == IDX_W'(k)) page_word = res_q[k];
    end
`ifdef READOUT_CHECKSUM_EN
    if (idx_next == IDX_W'(NUM_RESULTS)) page_word = chk_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ack_d   = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
`ifdef READOUT_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (done) begin
          for (int unsigned k = 0; k < NUM_RESULTS; k++) begin
            res_d[k] = res_bus[k*DATA_W +: DATA_W];
          end
`ifdef READOUT_CHECKSUM_EN
          chk_d = bus_xor;
`endif
          idx_d   = '0;
          data_d  = res_bus[DATA_W-1:0];
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (press) begin
          idx_d  = idx_next;
          data_d = page_word;
        end
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides capture and paging in every state.
    if (clear) begin
      state_d = IDLE;
      for (int unsigned k = 0; k < NUM_RESULTS; k++) res_d[k] = '0;
`ifdef READOUT_CHECKSUM_EN
      chk_d   = '0;
`endif
      ack_d   = 1'b0;
      valid_d = 1'b0;
      data_d  = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NUM_RESULTS; k++) res_q[k] <= '0;
`ifdef READOUT_CHECKSUM_EN
      chk_q   <= '0;
`endif
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
`ifdef READOUT_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign ack      = ack_q;
  assign valid    = valid_q;
  assign led_data = data_q;
  assign led_idx  = idx_q;

endmodule

// File: tb/tb_result_readout_seq.sv
// Self-checking bench for result_readout_seq: directed scenarios followed by random traffic.
module tb_result_readout_seq;

`ifdef READOUT_CHECKSUM_EN
  localparam int LAST = 2;
`else
  localparam int LAST = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, done, key_n, clear;
  logic [31:0] res_bus;
  logic        ack, valid;
  logic [15:0] led_data;
  logic [1:0]  led_idx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_show;
  logic [15:0] m_w [2];
  int          m_idx;
  logic [15:0] m_data;
  bit          m_valid, m_ack;
  bit          kh [3];

  always #5 clk = ~clk;

  result_readout_seq #(.DATA_W(16), .NUM_RESULTS(2), .IDX_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .res_bus  (res_bus),
    .key_n    (key_n),
    .clear    (clear),
    .ack      (ack),
    .valid    (valid),
    .led_data (led_data),
    .led_idx  (led_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] slot(input int i);
    if (i < 2) return m_w[i];
    return m_w[0] ^ m_w[1];
  endfunction

  // One clock: drive at negedge, update the model at the edge, compare just after.
  task automatic step(input logic r, input logic d, input logic c, input logic k,
                      input logic [31:0] b);
    bit press;
    @(negedge clk);
    rst = r; done = d; clear = c; key_n = k; res_bus = b;
    @(posedge clk);
    press = (kh[1] == 1'b0) && (kh[2] == 1'b1);
    if (r) begin
      kh = '{1'b1, 1'b1, 1'b1};
      m_show = 0; m_w[0] = '0; m_w[1] = '0;
      m_idx = 0; m_data = '0; m_valid = 0; m_ack = 0;
    end else begin
      kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = k;
      if (c) begin
        m_show = 0; m_w[0] = '0; m_w[1] = '0;
        m_idx = 0; m_data = '0; m_valid = 0; m_ack = 0;
      end else if (!m_show) begin
        m_ack = 0;
        if (d) begin
          m_w[0] = b[15:0]; m_w[1] = b[31:16];
          m_show = 1; m_idx = 0; m_data = m_w[0]; m_valid = 1; m_ack = 1;
        end
      end else begin
        m_ack = 0;
        if (press) begin
          m_idx  = (m_idx == LAST) ? 0 : m_idx + 1;
          m_data = slot(m_idx);
        end
      end
    end
    #1;
    check("ack",      32'(ack),      32'(m_ack));
    check("valid",    32'(valid),    32'(m_valid));
    check("led_data", 32'(led_data), 32'(m_data));
    check("led_idx",  32'(led_idx),  32'(m_idx));
  endtask

  task automatic press_key(input logic [31:0] b);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, b);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, b);
  endtask

  localparam logic [31:0] BUS0 = {16'h00A5, 16'h1234};

  initial begin
    logic kcur;
    rst = 1; done = 0; clear = 0; key_n = 1; res_bus = '0;
    kh = '{1'b1, 1'b1, 1'b1};
    m_show = 0; m_w[0] = '0; m_w[1] = '0; m_idx = 0; m_data = '0; m_valid = 0; m_ack = 0;

    step(1, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(led_data), 32'd0);

    // Capture with a one-cycle done
    step(0, 1, 0, 1, BUS0);
    check("cap_ack",  32'(ack), 32'd1);
    check("cap_data", 32'(led_data), 32'h1234);
    step(0, 0, 0, 1, BUS0);
    check("cap_ack_pulse", 32'(ack), 32'd0);

    // Paging
    press_key(BUS0);
    check("pg1_idx",  32'(led_idx), 32'd1);
    check("pg1_data", 32'(led_data), 32'h00A5);
    press_key(BUS0);
`ifdef READOUT_CHECKSUM_EN
    check("pg2_idx",  32'(led_idx), 32'd2);
    check("pg2_data", 32'(led_data), 32'h1291);
    press_key(BUS0);
    check("pg3_idx",  32'(led_idx), 32'd0);
`else
    check("pg2_idx",  32'(led_idx), 32'd0);
    check("pg2_data", 32'(led_data), 32'h1234);
`endif

    // Long hold with done low and bus changed: exactly one advance
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hFFFF_FFFF);
    check("hold_idx",  32'(led_idx), 32'd1);
    check("hold_data", 32'(led_data), 32'h00A5);

    // Clear coinciding with a press, done held high for recapture
    step(0, 0, 0, 0, BUS0);
    step(0, 0, 0, 0, BUS0);
    step(0, 1, 1, 0, BUS0);
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_idx",   32'(led_idx), 32'd0);
    step(0, 1, 0, 1, 32'h0BAD_0F00);
    check("recap_ack",  32'(ack), 32'd1);
    check("recap_data", 32'(led_data), 32'h0F00);
    step(0, 0, 0, 1, BUS0);

    // Reset while showing
    step(1, 0, 0, 1, BUS0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, BUS0);
    check("post_rst_ack", 32'(ack), 32'd0);

    // Random traffic
    kcur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) kcur = ~kcur;
      step(($urandom_range(199) == 0), ($urandom_range(7) == 0),
           ($urandom_range(39) == 0), kcur, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
